uart_time_encoder: RTL and testbench
====================================

Name: uart_time_encoder

Overview:
- Transmit-side counterpart of the UART command decoder: formats the current watch time as an ASCII line and pushes it byte by byte into the UART TX FIFO.
- Sits between the watch/stopwatch datapath (time values) and the TX FIFO write port.
- A one-cycle request (e.g. the decoded "mode" pulse or a periodic tick) triggers one message.
- Backpressure comes from the FIFO full flag.

Parameters:
- MSG_TERM_CR, 1, 1 = append "\r" before "\n"; 0 = "\n" only (message length drops by 1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
- i_req  input  1  one-cycle send request
- i_hour  input  5  hours, 0-31 accepted
- i_min  input  6  minutes, 0-63 accepted
- i_sec  input  6  seconds, 0-63 accepted
- i_csec  input  7  centiseconds, 0-127 accepted (used only with CENTISEC_EN)
- i_full  input  1  TX FIFO full
- o_tx_data  output  8  ASCII byte to FIFO
- o_push  output  1  FIFO write strobe
- o_busy  output  1  message in progress
- o_done  output  1  one-cycle pulse after last byte pushed

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, byte index=0, pending=0, snapshot regs=0.
  - o_push=0, o_done=0, o_busy=0, o_tx_data=8'h00.
  - Reset mid-message aborts it immediately; no further pushes.
- FSM states: IDLE, SEND, DONE.
  - IDLE: if i_req=1 at an edge, capture i_hour/i_min/i_sec/i_csec into snapshot regs, index=0, go to SEND.
  - SEND:
    - o_push = ~i_full (combinational); o_tx_data = byte[index] (combinational from snapshot and index).
    - At each edge with ~i_full: index++. When the last byte is pushed, go to DONE.
    - i_full=1 stalls: index holds, o_tx_data stable, o_push=0.
  - DONE: o_done=1 for exactly this cycle.
    - If pending=1: re-snapshot the current inputs, clear pending, index=0, go to SEND.
    - Otherwise go to IDLE.
- o_busy = (state != IDLE).
- Request during SEND or DONE: sets pending (1-deep).
  - Multiple requests collapse into one.
  - A request in the same DONE cycle that consumes pending re-sets pending.
- Message, no CENTISEC_EN, MSG_TERM_CR=1 (10 bytes): H1 H0 ':' M1 M0 ':' S1 S0 '\r' '\n'.
- Digit rule for value v:
  - v>99 clamps to 99.
  - tens = v/10, ones = v-10*tens, each emitted as 8'h30+digit.
  - Division uses a compare/subtract chain, no '/' operator.
  - Snapshot values never change during a message; no tearing.
- Latency with i_full=0:
  - i_req at edge N gives the first push in cycle N+1 and the last push in cycle N+10.
  - o_done in cycle N+11, o_busy low in cycle N+12 if no pending request.
- Throughput: one byte per cycle when not full.
- o_tx_data = 8'h00 whenever state != SEND.

Optional Feature:
- Macro: UART_TIME_ENCODER_CENTISEC_EN.
- Defined:
  - Message inserts '.' C1 C0 after S0, giving "HH:MM:SS.CC\r\n" (13 bytes, 12 with MSG_TERM_CR=0).
  - i_csec is snapshot and clamped to 99.
- Undefined:
  - i_csec is ignored (no snapshot register).
  - Message is 10/9 bytes as above.

Test Plan:
- Basic format: rst low 2 cycles, then high; hour=13, min=5, sec=42; pulse i_req; i_full=0 -> 10 consecutive pushes 31 33 3A 30 35 3A 34 32 0D 0A, o_done 1 cycle later, o_busy high 11 cycles.
- Backpressure: same stimulus, i_full=1 during cycles 3-6 of the message -> o_push low and o_tx_data held at 8'h3A during the stall; byte stream identical; o_done delayed 4 cycles.
- Snapshot/pending: i_req with sec=9; change sec to 10 mid-message; second i_req at byte 4 plus third at byte 6 -> first message "..:09", exactly one follow-up message with "..:10", one o_done per message, no IDLE cycle between them.
- Clamp/boundaries: hour=31, min=63, sec=0 -> "31:63:00"; with CENTISEC_EN, csec=127 -> ".99"; csec=0 -> ".00".
- Reset mid-operation: rst=0 after byte 5 -> o_push=0, o_busy=0, pending cleared next cycle; new i_req restarts from byte 0 (8'h3X hour tens).
- MSG_TERM_CR=0: hour=0, min=0, sec=0 -> 9 bytes ending 30 30 0A, no 0D.

Source files
------------

// File: rtl/uart_time_encoder.sv
// -----------------------------------------------------------------------------
// uart_time_encoder
//
// Formats a snapshot of the watch time as an ASCII line "HH:MM:SS\r\n" and
// pushes it one byte per cycle into the UART TX FIFO. FIFO full stalls the
// stream. A request arriving while a message is in flight is remembered
// (1-deep) and produces exactly one follow-up message with fresh time values.
//
// Optional feature (compile-time macro UART_TIME_ENCODER_CENTISEC_EN):
//   defined   -> ".CC" centiseconds are inserted after the seconds field
//   undefined -> i_csec is ignored
//
// Parameter:
//   MSG_TERM_CR  1: line ends "\r\n", 0: line ends "\n"
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   i_req      one-cycle send request
//   i_hour     hours        (0-31, shown clamped to 99)
//   i_min      minutes      (0-63)
//   i_sec      seconds      (0-63)
//   i_csec     centiseconds (0-127, clamped to 99, centisecond build only)
//   i_full     TX FIFO full
//   o_tx_data  ASCII byte to FIFO (8'h00 outside a message)
//   o_push     FIFO write strobe
//   o_busy     message in progress
//   o_done     one-cycle pulse after the last byte was pushed
// -----------------------------------------------------------------------------
module uart_time_encoder #(
   parameter logic MSG_TERM_CR = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req,
   input  logic [4:0] i_hour,
   input  logic [5:0] i_min,
   input  logic [5:0] i_sec,
   input  logic [6:0] i_csec,
   input  logic       i_full,
   output logic [7:0] o_tx_data,
   output logic       o_push,
   output logic       o_busy,
   output logic       o_done
);

`ifdef UART_TIME_ENCODER_CENTISEC_EN
   localparam int DIGIT_BYTES = 11;
`else
   localparam int DIGIT_BYTES = 8;
`endif
   localparam int         MSG_LEN  = DIGIT_BYTES + (MSG_TERM_CR ? 2 : 1);
   localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
   localparam logic [3:0] TERM_IDX = 4'(DIGIT_BYTES);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t     state, state_d;
   logic [3:0] idx, idx_d;
   logic       pending, pending_d;
   logic       load;

   logic [4:0] hour_q;
   logic [5:0] min_q;
   logic [5:0] sec_q;
`ifdef UART_TIME_ENCODER_CENTISEC_EN
   logic [6:0] csec_q;
`else
   logic       unused_csec;
   assign unused_csec = ^i_csec;
`endif

   // Two ASCII digits {tens, ones} of a value clamped to 99. The tens digit
   // comes from a compare chain so no divider is synthesised.
   function automatic logic [15:0] to_ascii(input logic [6:0] v);
      logic [6:0] c;
      logic [3:0] t;
      logic [3:0] o;
      c = (v > 7'd99) ? 7'd99 : v;
      t = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         if (c >= 7'(10 * k)) t = 4'(k);
      end
      o = 4'(c - 7'(10 * t));
      return {4'h3, t, 4'h3, o};
   endfunction

   logic [15:0] hour_asc, min_asc, sec_asc;
   assign hour_asc = to_ascii({2'b00, hour_q});
   assign min_asc  = to_ascii({1'b0, min_q});
   assign sec_asc  = to_ascii({1'b0, sec_q});
`ifdef UART_TIME_ENCODER_CENTISEC_EN
   logic [15:0] csec_asc;
   assign csec_asc = to_ascii(csec_q);
`endif

   // Byte selected by the current index, built from the frozen snapshot.
   logic [7:0] msg_byte;
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      msg_byte = 8'h00;
      case (idx)
         4'd0:    msg_byte = hour_asc[15:8];
         4'd1:    msg_byte = hour_asc[7:0];
         4'd2:    msg_byte = 8'h3A;
         4'd3:    msg_byte = min_asc[15:8];
         4'd4:    msg_byte = min_asc[7:0];
         4'd5:    msg_byte = 8'h3A;
         4'd6:    msg_byte = sec_asc[15:8];
         4'd7:    msg_byte = sec_asc[7:0];
`ifdef UART_TIME_ENCODER_CENTISEC_EN
         4'd8:    msg_byte = 8'h2E;
         4'd9:    msg_byte = csec_asc[15:8];
         4'd10:   msg_byte = csec_asc[7:0];
`endif
         default: msg_byte = 8'h00;
      endcase
      if (idx == TERM_IDX)
         msg_byte = MSG_TERM_CR ? 8'h0D : 8'h0A;
      else if (MSG_TERM_CR && idx == TERM_IDX + 4'd1)
         msg_byte = 8'h0A;
   end

   // Next-state logic. A request seen in DONE is stored even when the
   // pending one is being consumed in the same cycle.
   always_comb begin
      state_d   = state;
      idx_d     = idx;
      pending_d = pending;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (i_req) begin
               load    = 1'b1;
               idx_d   = 4'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (i_req) pending_d = 1'b1;
            if (!i_full) begin
               if (idx == LAST_IDX) state_d = DONE;
               else                 idx_d   = idx + 4'd1;
            end
         end
         DONE: begin
            pending_d = i_req;
            idx_d     = 4'd0;
            if (pending) begin
               load    = 1'b1;
               state_d = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this edge.
      if (!rst) begin
         state   <= IDLE;
         idx     <= 4'd0;
         pending <= 1'b0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
`ifdef UART_TIME_ENCODER_CENTISEC_EN
         csec_q  <= '0;
`endif
      end else begin
         state   <= state_d;
         idx     <= idx_d;
         pending <= pending_d;
         if (load) begin
            hour_q <= i_hour;
            min_q  <= i_min;
            sec_q  <= i_sec;
`ifdef UART_TIME_ENCODER_CENTISEC_EN
            csec_q <= i_csec;
`endif
         end
      end
   end

   assign o_push    = (state == SEND) && !i_full;
   assign o_tx_data = (state == SEND) ? msg_byte : 8'h00;
   assign o_busy    = (state != IDLE);
   assign o_done    = (state == DONE);

endmodule

// File: tb/tb_uart_time_encoder.sv
// -----------------------------------------------------------------------------
// tb_uart_time_encoder
//
// Drives two encoders from the same stimulus: one ending lines with "\r\n"
// and one ending with "\n". A message-level model (precomputed ASCII line plus
// a read position, a done flag and a pending flag) predicts all outputs every
// cycle; directed scenarios additionally pin the byte streams to literals.
// -----------------------------------------------------------------------------
module tb_uart_time_encoder;

`ifdef UART_TIME_ENCODER_CENTISEC_EN
   localparam int ML1 = 13;
`else
   localparam int ML1 = 10;
`endif
   localparam int ML0 = ML1 - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req = 1'b0;
   logic [4:0] hour = '0;
   logic [5:0] min = '0;
   logic [5:0] sec = '0;
   logic [6:0] csec = '0;
   logic       full = 1'b0;

   logic [7:0] data1, data0;
   logic       push1, push0, busy1, busy0, done1, done0;

   always #5 clk = ~clk;

   uart_time_encoder #(.MSG_TERM_CR(1'b1)) dut_cr (
      .clk(clk), .rst(rst), .i_req(req), .i_hour(hour), .i_min(min),
      .i_sec(sec), .i_csec(csec), .i_full(full),
      .o_tx_data(data1), .o_push(push1), .o_busy(busy1), .o_done(done1)
   );

   uart_time_encoder #(.MSG_TERM_CR(1'b0)) dut_lf (
      .clk(clk), .rst(rst), .i_req(req), .i_hour(hour), .i_min(min),
      .i_sec(sec), .i_csec(csec), .i_full(full),
      .o_tx_data(data0), .o_push(push0), .o_busy(busy0), .o_done(done0)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 1: CR+LF, index 0: LF) -------
   logic [7:0] m_msg [2][16];
   int         m_pos [2];
   bit         m_active [2];
   bit         m_done [2];
   bit         m_pend [2];
   bit         model_valid = 1'b0;

   function automatic void build(int k);
      int vals [4];
      int n, nf, d;
      vals[0] = int'(hour); vals[1] = int'(min); vals[2] = int'(sec); vals[3] = int'(csec);
`ifdef UART_TIME_ENCODER_CENTISEC_EN
      nf = 4;
`else
      nf = 3;
`endif
      n = 0;
      for (int f = 0; f < nf; f++) begin
         if (f > 0) begin
            m_msg[k][n] = (f == 3) ? 8'h2E : 8'h3A;
            n++;
         end
         d = (vals[f] > 99) ? 99 : vals[f];
         m_msg[k][n]     = 8'(48 + d / 10);
         m_msg[k][n + 1] = 8'(48 + d % 10);
         n += 2;
      end
      if (k == 1) begin
         m_msg[k][n] = 8'h0D;
         n++;
      end
      m_msg[k][n] = 8'h0A;
   endfunction

   logic [7:0] cap1 [$];
   logic [7:0] cap0 [$];
   int busy_cnt1 = 0, busy_cnt0 = 0, done_cnt1 = 0, done_cnt0 = 0;

   // Compare, capture, then advance the model over the coming rising edge
   // (inputs are stable from here until that edge).
   always @(negedge clk) begin
      if (model_valid) begin
         for (int k = 0; k < 2; k++) begin
            logic [7:0] a_data;
            logic       a_push, a_busy, a_done;
            a_data = k ? data1 : data0;
            a_push = k ? push1 : push0;
            a_busy = k ? busy1 : busy0;
            a_done = k ? done1 : done0;
            check($sformatf("push[%0d]", k), 32'(a_push), 32'(m_active[k] && !full));
            check($sformatf("data[%0d]", k), 32'(a_data), 32'(m_active[k] ? m_msg[k][m_pos[k]] : 8'h00));
            check($sformatf("busy[%0d]", k), 32'(a_busy), 32'(m_active[k] || m_done[k]));
            check($sformatf("done[%0d]", k), 32'(a_done), 32'(m_done[k]));
         end
         if (push1) cap1.push_back(data1);
         if (push0) cap0.push_back(data0);
         if (busy1) busy_cnt1++;
         if (busy0) busy_cnt0++;
         if (done1) done_cnt1++;
         if (done0) done_cnt0++;
      end
      if (!rst) begin
         model_valid = 1'b1;
         for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_done[k] = 1'b0; m_pend[k] = 1'b0; m_pos[k] = 0;
         end
      end else if (model_valid) begin
         for (int k = 0; k < 2; k++) begin
            if (m_active[k]) begin
               if (!full) begin
                  m_pos[k]++;
                  if (m_pos[k] == (k ? ML1 : ML0)) begin
                     m_active[k] = 1'b0;
                     m_done[k]   = 1'b1;
                  end
               end
               if (req) m_pend[k] = 1'b1;
            end else if (m_done[k]) begin
               m_done[k] = 1'b0;
               if (m_pend[k]) begin
                  build(k);
                  m_active[k] = 1'b1; m_pos[k] = 0; m_pend[k] = 1'b0;
               end
               if (req) m_pend[k] = 1'b1;
            end else if (req) begin
               build(k);
               m_active[k] = 1'b1; m_pos[k] = 0;
            end
         end
      end
   end

   // ---------------- directed-test helpers ---------------------------------
   logic [7:0] lit_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_caps();
      cap1.delete(); cap0.delete();
      busy_cnt1 = 0; busy_cnt0 = 0; done_cnt1 = 0; done_cnt0 = 0;
   endtask

   task automatic pulse_req();
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   task automatic check_cap(input string name, input bit which);
      check({name, " len"}, which ? cap1.size() : cap0.size(), lit_q.size());
      for (int i = 0; i < lit_q.size(); i++) begin
         if (i < (which ? cap1.size() : cap0.size()))
            check($sformatf("%s byte%0d", name, i), which ? cap1[i] : cap0[i], lit_q[i]);
      end
   endtask

   initial begin
      // ---- reset, basic format --------------------------------------------
      rst = 1'b0;
      run(2);
      rst = 1'b1;
      check("reset busy", busy1, 1'b0);
      check("reset data", data1, 8'h00);
      hour = 5'd13; min = 6'd5; sec = 6'd42; csec = 7'd7;
      clear_caps();
      pulse_req();
      run(ML1 + 4);
      lit_q = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h34, 8'h32};
`ifdef UART_TIME_ENCODER_CENTISEC_EN
      lit_q.push_back(8'h2E); lit_q.push_back(8'h30); lit_q.push_back(8'h37);
`endif
      lit_q.push_back(8'h0D); lit_q.push_back(8'h0A);
      check_cap("basic", 1'b1);
      check("basic busy cycles", busy_cnt1, ML1 + 1);
      check("basic done count", done_cnt1, 1);

      // ---- backpressure: full during message cycles 3-6 --------------------
      clear_caps();
      pulse_req();
      run(2);
      full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall push", push1, 1'b0);
         check("stall data", data1, 8'h3A);
         tick();
      end
      full = 1'b0;
      run(ML1 + 2);
      check_cap("backpressure", 1'b1);
      check("backpressure busy cycles", busy_cnt1, ML1 + 5);

      // ---- snapshot / pending collapse --------------------------------------
      sec = 6'd9;
      clear_caps();
      pulse_req();
      run(2);
      sec = 6'd10;
      pulse_req();
      tick();
      pulse_req();
      run(2 * ML1 + 4);
      check("pending done count", done_cnt1, 2);
      check("pending busy cycles", busy_cnt1, 2 * ML1 + 2);
      check("pending len", cap1.size(), 2 * ML1);
      if (cap1.size() == 2 * ML1) begin
         check("first sec tens", cap1[6], 8'h30);
         check("first sec ones", cap1[7], 8'h39);
         check("second sec tens", cap1[ML1 + 6], 8'h31);
         check("second sec ones", cap1[ML1 + 7], 8'h30);
      end

      // ---- clamp / boundaries ------------------------------------------------
      hour = 5'd31; min = 6'd63; sec = 6'd0; csec = 7'd127;
      clear_caps();
      pulse_req();
      run(ML1 + 3);
      lit_q = '{8'h33, 8'h31, 8'h3A, 8'h36, 8'h33, 8'h3A, 8'h30, 8'h30};
`ifdef UART_TIME_ENCODER_CENTISEC_EN
      lit_q.push_back(8'h2E); lit_q.push_back(8'h39); lit_q.push_back(8'h39);
`endif
      lit_q.push_back(8'h0D); lit_q.push_back(8'h0A);
      check_cap("clamp", 1'b1);

      // ---- LF-only terminator with all-zero time -----------------------------
      hour = '0; min = '0; sec = '0; csec = '0;
      clear_caps();
      pulse_req();
      run(ML1 + 3);
      lit_q = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30};
`ifdef UART_TIME_ENCODER_CENTISEC_EN
      lit_q.push_back(8'h2E); lit_q.push_back(8'h30); lit_q.push_back(8'h30);
`endif
      lit_q.push_back(8'h0A);
      check_cap("lf only", 1'b0);

      // ---- reset mid-message, pending must be dropped ------------------------
      hour = 5'd23;
      pulse_req();
      run(1);
      pulse_req();
      run(3);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      clear_caps();
      run(ML1 + 3);
      check("post-reset busy", busy_cnt1, 0);
      check("post-reset pushes", cap1.size(), 0);
      pulse_req();
      run(ML1 + 3);
      check("restart len", cap1.size(), ML1);
      if (cap1.size() > 0) check("restart first byte", cap1[0], 8'h32);

      // ---- randomized traffic ------------------------------------------------
      for (int i = 0; i < 3000; i++) begin
         req  = ($urandom_range(0, 7) == 0);
         full = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 3) == 0) begin
            hour = 5'($urandom); min = 6'($urandom);
            sec  = 6'($urandom); csec = 7'($urandom);
         end
         tick();
      end
      req = 1'b0; full = 1'b0; rst = 1'b1;
      run(2 * ML1 + 4);
      check("random drains", busy1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
